// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one off-chip memory port between the I-cache and D-cache.
// Each granted transaction is held on registered strobes until mem_ready, then released.
module mem_arbiter #(
    parameter int unsigned ADDR_W = 28,
    parameter int unsigned DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ic_read,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic [DATA_W-1:0] ic_rdata,
    output logic              ic_ready,
    input  logic              dc_read,
    input  logic              dc_write,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [DATA_W-1:0] dc_wdata,
    output logic [DATA_W-1:0] dc_rdata,
    output logic              dc_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    typedef enum logic [1:0] {
        StIdle,
        StGrantI,
        StGrantD,
        StRelease
    } state_e;

    state_e            state_q, state_d;
    logic              last_dc_q, last_dc_d;  // 1 when the D side won the most recent grant
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              i_pend, d_pend, pick_dc;

    always_comb begin
        state_d     = state_q;
        last_dc_d   = last_dc_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        i_pend  = ic_read;
        d_pend  = dc_read | dc_write;
        // On a tie the side that did not win last time goes first.
        pick_dc = d_pend & (~i_pend | ~last_dc_q);

        unique case (state_q)
            StIdle: begin
                if (pick_dc) begin
                    state_d     = StGrantD;
                    last_dc_d   = 1'b1;
                    mem_write_d = dc_write;
                    mem_read_d  = ~dc_write;
                    mem_addr_d  = dc_addr;
                    mem_wdata_d = dc_wdata;
                end else if (i_pend) begin
                    state_d     = StGrantI;
                    last_dc_d   = 1'b0;
                    mem_read_d  = 1'b1;
                    mem_write_d = 1'b0;
                    mem_addr_d  = ic_addr;
                end
            end
            StGrantI, StGrantD: begin
                if (mem_ready) begin
                    state_d     = StRelease;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                end
            end
            StRelease: begin
                state_d = StIdle;
            end
            default: begin
                state_d     = StIdle;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            last_dc_q   <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            last_dc_q   <= last_dc_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    // Completion is routed only to the side that owns the port; stray pulses are dropped.
    assign ic_ready = mem_ready & (state_q == StGrantI);
    assign dc_ready = mem_ready & (state_q == StGrantD);
    assign ic_rdata = mem_rdata;
    assign dc_rdata = mem_rdata;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter that shares the single off-chip memory port between the I-cache and the D-cache miss/write-back paths.
- Sits between both cache memory interfaces and the slow memory model, so that one memory is used for instructions and data.
- Arbitration is round-robin when both caches request in the same cycle, so neither side can starve the other.
- The full memory transaction is held for the granted side until the memory returns ready.

Parameters:
- ADDR_W, 28, line-address width (word address / 4).
- DATA_W, 128, cache-line width in bits.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-low reset.
- ic_read  input  1  I-cache line-read request, level, held until ic_ready.
- ic_addr  input  ADDR_W  I-cache line address.
- ic_rdata  output  DATA_W  read line to I-cache.
- ic_ready  output  1  one-cycle completion pulse to I-cache.
- dc_read  input  1  D-cache line-read request, level, held until dc_ready.
- dc_write  input  1  D-cache line write-back request, level, held until dc_ready.
- dc_addr  input  ADDR_W  D-cache line address.
- dc_wdata  input  DATA_W  D-cache write-back line.
- dc_rdata  output  DATA_W  read line to D-cache.
- dc_ready  output  1  one-cycle completion pulse to D-cache.
- mem_read  output  1  memory read strobe, registered.
- mem_write  output  1  memory write strobe, registered.
- mem_addr  output  ADDR_W  memory line address, registered.
- mem_wdata  output  DATA_W  memory write line, registered.
- mem_rdata  input  DATA_W  memory read line.
- mem_ready  input  1  memory completion pulse, one cycle.

Behaviour:
Clock, reset and reset values
- One clock, clk.
- rst is asynchronous, active-low.
- On reset: state = IDLE, last_grant = I (so D wins the first tie).
- mem_read = 0, mem_write = 0, mem_addr = 0, mem_wdata = 0.
- ic_ready = 0, dc_ready = 0.
- A reset asserted mid-transaction drops mem_read and mem_write immediately. The in-flight transaction is abandoned and no ready pulse is issued.

State machine: IDLE, GRANT_I, GRANT_D, RELEASE.
- IDLE, request sampled at cycle t:
  - D pending = dc_read | dc_write. I pending = ic_read.
  - Only one side pending: grant that side.
  - Both pending: grant the side opposite to last_grant.
  - On grant, register mem_addr, mem_wdata and the strobes. The strobes are high from cycle t+1. Update last_grant.
  - No request: stay in IDLE, strobes 0.
- GRANT_I:
  - mem_read = 1, mem_write = 0, registered ic_addr.
  - Hold until mem_ready, then RELEASE.
- GRANT_D:
  - mem_write = dc_write (captured at grant), mem_read = ~dc_write.
  - If dc_read and dc_write are both high at grant, the write takes precedence.
  - Hold until mem_ready, then RELEASE.
- RELEASE:
  - Strobes 0 for exactly one cycle, so the requester can deassert. Then IDLE.
  - A request visible during RELEASE is not granted until IDLE samples it.

Ready and read data
- ic_ready = mem_ready & (state == GRANT_I). dc_ready = mem_ready & (state == GRANT_D).
- Both are combinational, the same cycle as mem_ready.
- ic_rdata and dc_rdata both mirror mem_rdata. Only the ready of the granted side is meaningful.
- mem_ready in IDLE or RELEASE is ignored and forwarded to neither side.

Other rules
- Requester address and data changes after grant are ignored, because the latched copies are used.
- Minimum turnaround from request to next grant: grant cycle + memory latency + 1 RELEASE cycle.
- Width rule: all address and data paths are pass-through at ADDR_W and DATA_W. No arithmetic.

Test Plan:
- I-only: ic_read = 1, ic_addr = 28'h0000010, memory latency 8.
  - Required: mem_read high from the next cycle with mem_addr = 28'h0000010.
  - ic_ready pulses once with ic_rdata = mem_rdata; dc_ready stays 0.
- D write-back: dc_write = 1, dc_addr = 28'h0000100, dc_wdata = 128'hFFFF…0000.
  - Required: mem_write = 1 and mem_read = 0, with the same address and data.
  - dc_ready pulses once, then one cycle with both strobes 0.
- Tie after reset: ic_read and dc_read both asserted in the same cycle.
  - Required: D is granted first.
  - I is granted at the first IDLE after D's RELEASE.
  - A following tie is granted to D.
- Both dc_read and dc_write high at grant.
  - Required: only mem_write = 1.
- Stray mem_ready pulse in IDLE.
  - Required: ic_ready = dc_ready = 0 and no state change.
- Reset mid-op: rst low 3 cycles into GRANT_D.
  - Required: mem_read and mem_write go to 0 asynchronously, no ready pulse, and state is IDLE after release.
